stim_seq_checker: RTL and testbench
===================================

Name: stim_seq_checker

Overview:
- Synthesizable upstream/downstream companion to the gate-level delay circuit (inputs A,B,C; outputs x = (A&B)|~C, y = ~C).
- Drives all 8 {A,B,C} combinations in sequence, holding each for a programmable number of cycles.
- Samples x,y after a settle window and compares them against a built-in golden model.
- Reports pass/fail, a saturating mismatch count and the first failing vector. Replaces the hand-written initial-block stimulus for on-board and regression use.

Parameters:
- HOLD_CYCLES, 10, clocks each vector is held on A,B,C; legal range 2..255.
- SETTLE_CYCLES, 6, clocks after vector change at which x,y are sampled; legal range 1..HOLD_CYCLES-1.
- NUM_PASSES, 1, number of full 8-vector sweeps per run; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request; honoured only in IDLE or DONE.
- A  output  1  stimulus, vec[2].
- B  output  1  stimulus, vec[1].
- C  output  1  stimulus, vec[0].
- x_in  input  1  DUT output x, synchronous to clk.
- y_in  input  1  DUT output y, synchronous to clk.
- busy  output  1  high from first HOLD cycle until DONE entry.
- done  output  1  high in DONE; sticky until next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  8  mismatching samples, saturates at 255.
- first_fail  output  3  vector index of first mismatch; valid when fail_seen=1.
- fail_seen  output  1  set on first mismatch of a run.

Behaviour:
- Reset (async assert, sync release): state=IDLE; A,B,C, busy, done, pass, err_count, first_fail, fail_seen, vec, hold_cnt and pass_cnt all 0.
- Vector encoding: {A,B,C} = vec[2:0], registered outputs, no combinational path from any input.
- Golden model: exp_x = (A&B)|~C; exp_y = ~C.
- Expected outputs per vec 0..7: x = 1,0,1,0,1,0,1,1; y = 1,0,1,0,1,0,1,0.
- States: IDLE, HOLD, DONE.
- IDLE:
  - start=1 -> HOLD next cycle.
  - On entry to HOLD: vec=0, hold_cnt=0, pass_cnt=0, err_count=0, fail_seen=0, first_fail=0, done=0, pass=0, busy=1.
- HOLD:
  - hold_cnt increments every cycle, 0..HOLD_CYCLES-1.
  - Compare at hold_cnt==SETTLE_CYCLES-1 only: one compare per vector per pass.
  - Mismatch means x_in!=exp_x OR y_in!=exp_y; counts as 1 even if both bits differ.
  - On mismatch: err_count += 1 unless already 255. If fail_seen==0, then first_fail=vec and fail_seen=1.
  - At hold_cnt==HOLD_CYCLES-1: hold_cnt=0 and vec wraps 7->0.
  - When vec wraps 7->0, pass_cnt increments.
  - When vec==7 and pass_cnt==NUM_PASSES-1 -> DONE instead of advancing.
- DONE:
  - busy=0, done=1, pass=(err_count==0). A,B,C hold last vector (111).
  - start=1 -> HOLD with full clear, as from IDLE.
- start while busy: ignored; no restart, no counter effect.
- Run latency: 1 + 8*NUM_PASSES*HOLD_CYCLES clocks from start sampled to done=1.
- rst_n low mid-run: immediate return to reset values, including A,B,C.
- Parameter checks: simulation-only assertion fires if SETTLE_CYCLES >= HOLD_CYCLES.

Test Plan:
- Golden-model DUT, defaults, start pulse -> A,B,C step 000..111 every 10 clocks; done=1 at clock 81 after start; pass=1, err_count=0, fail_seen=0.
- x_in stuck 0 -> err_count=5 (vecs 0,2,4,6,7), first_fail=0, pass=0.
- y_in stuck 1 -> err_count=4 (vecs 1,3,5,7), first_fail=1, pass=0.
- NUM_PASSES=2, x_in stuck 0 -> done at clock 161, err_count=10.
- NUM_PASSES=15, HOLD_CYCLES=2, SETTLE_CYCLES=1, x_in,y_in inverted -> 120 errors, no overflow. With additional forced mismatch injection beyond 255 samples -> err_count saturates at 255, no wrap.
- start re-pulsed at clock 30 of a run -> ignored, done still at clock 81. rst_n low at clock 45 -> all outputs 0 asynchronously. Restart after release -> clean run, pass=1.

Source files
------------

// File: rtl/stim_seq_checker_if.sv
// stim_seq_checker_if: stimulus and response bundle between the sequencer-checker and the circuit under test.
interface stim_seq_checker_if;
    logic       start;
    logic       A;
    logic       B;
    logic       C;
    logic       x_in;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [2:0] first_fail;
    logic       fail_seen;
    modport master (
        input  start, x_in, y_in,
        output A, B, C, busy, done, pass, err_count, first_fail, fail_seen
    );
    modport slave (
        output start, x_in, y_in,
        input  A, B, C, busy, done, pass, err_count, first_fail, fail_seen
    );
endinterface

// File: rtl/stim_seq_checker.sv
// stim_seq_checker: sweeps all eight {A,B,C} vectors, samples x/y after a settle window
// and scores them against (A&B)|~C and ~C.
module stim_seq_checker #(
    parameter int HOLD_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 6,
    parameter int NUM_PASSES    = 1
) (
    input logic clk,
    input logic rst_n,
    stim_seq_checker_if.master bus
);
    localparam int PW = $clog2(NUM_PASSES + 1);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
    state_t        state_q, state_d;
    logic [2:0]    vec_q, vec_d, first_fail_q, first_fail_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d, err_q, err_d;
    logic [PW-1:0] pass_cnt_q, pass_cnt_d;
    logic          fail_seen_q, fail_seen_d;
    logic          exp_x, exp_y, mismatch, last_hold;
    assign exp_x     = (vec_q[2] & vec_q[1]) | ~vec_q[0];
    assign exp_y     = ~vec_q[0];
    assign mismatch  = (bus.x_in != exp_x) || (bus.y_in != exp_y);
    assign last_hold = hold_cnt_q == 8'(HOLD_CYCLES - 1);
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        hold_cnt_d   = hold_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        if (state_q != HOLD) begin
            if (bus.start) begin
                state_d      = HOLD;
                vec_d        = '0;
                hold_cnt_d   = '0;
                pass_cnt_d   = '0;
                err_d        = '0;
                first_fail_d = '0;
                fail_seen_d  = 1'b0;
            end
        end else begin
            hold_cnt_d = last_hold ? '0 : hold_cnt_q + 8'd1;
            if (hold_cnt_q == 8'(SETTLE_CYCLES - 1) && mismatch) begin
                err_d        = err_q + {7'd0, err_q != 8'hff};
                first_fail_d = fail_seen_q ? first_fail_q : vec_q;
                fail_seen_d  = 1'b1;
            end
            // The last vector of the last pass ends the run instead of wrapping.
            if (last_hold) begin
                if (vec_q == 3'd7 && pass_cnt_q == PW'(NUM_PASSES - 1)) begin
                    state_d = DONE;
                end else begin
                    vec_d      = vec_q + 3'd1;
                    pass_cnt_d = pass_cnt_q + PW'(vec_q == 3'd7);
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            hold_cnt_q   <= '0;
            pass_cnt_q   <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            hold_cnt_q   <= hold_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end
    always_ff @(posedge clk)
        assert (SETTLE_CYCLES < HOLD_CYCLES) else $error("SETTLE_CYCLES must be below HOLD_CYCLES");
    assign {bus.A, bus.B, bus.C} = vec_q;
    assign bus.busy       = state_q == HOLD;
    assign bus.done       = state_q == DONE;
    assign bus.pass       = state_q == DONE && err_q == 8'd0;
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_fail_q;
    assign bus.fail_seen  = fail_seen_q;
endmodule

// File: tb/tb_stim_seq_checker.sv
// tb_stim_seq_checker: drives four checker instances with golden, stuck, inverted and random responses
// and scores them against a per-cycle reference of the sweep schedule.
module tb_stim_seq_checker;
    localparam int H = 10;
    localparam int S = 6;
    logic clk = 1'b0;
    logic rst_n;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] xt = 8'b1101_0101;
    logic [7:0] yt = 8'b0101_0101;
    always #5 clk = ~clk;
    stim_seq_checker_if b0 ();
    stim_seq_checker_if b1 ();
    stim_seq_checker_if b2 ();
    stim_seq_checker_if b3 ();
    stim_seq_checker #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .NUM_PASSES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    stim_seq_checker #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .NUM_PASSES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    stim_seq_checker #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .NUM_PASSES(15)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    stim_seq_checker #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .NUM_PASSES(33)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    assign b1.x_in = 1'b0;
    assign b1.y_in = yt[{b1.A, b1.B, b1.C}];
    assign b2.x_in = ~xt[{b2.A, b2.B, b2.C}];
    assign b2.y_in = ~yt[{b2.A, b2.B, b2.C}];
    assign b3.x_in = ~xt[{b3.A, b3.B, b3.C}];
    assign b3.y_in = ~yt[{b3.A, b3.B, b3.C}];
    wire [17:0] o0 = {b0.A, b0.B, b0.C, b0.busy, b0.done, b0.pass, b0.err_count, b0.first_fail, b0.fail_seen};
    wire [17:0] o1 = {b1.A, b1.B, b1.C, b1.busy, b1.done, b1.pass, b1.err_count, b1.first_fail, b1.fail_seen};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic kick(input logic [3:0] m);
        @(negedge clk);
        {b3.start, b2.start, b1.start, b0.start} = m;
        @(negedge clk);
        {b3.start, b2.start, b1.start, b0.start} = 4'b0;
    endtask
    // mode 0 golden, 1 x stuck 0, 2 y stuck 1, 3 random bit flips; rp = cycle of a stray start pulse
    task automatic run_d0(input int mode, input int rp);
        int exp_err = 0;
        int ff = -1;
        logic [2:0] v;
        logic xv, yv;
        for (int t = 0; t < 8 * H; t++) begin
            v = 3'(t / H);
            chk("abc", {b0.A, b0.B, b0.C}, v);
            chk("busy_done", {b0.busy, b0.done}, 2'b10);
            xv = (mode == 1) ? 1'b0 : xt[v];
            yv = (mode == 2) ? 1'b1 : yt[v];
            if (mode == 3) begin
                xv = xv ^ ($urandom_range(0, 3) == 0);
                yv = yv ^ ($urandom_range(0, 3) == 0);
            end
            b0.x_in = xv;
            b0.y_in = yv;
            b0.start = (t == rp);
            if (t % H == S - 1 && (xv != xt[v] || yv != yt[v])) begin
                exp_err++;
                if (ff < 0) ff = int'(v);
            end
            @(negedge clk);
        end
        b0.start = 1'b0;
        chk("done", {b0.busy, b0.done}, 2'b01);
        chk("abc_done", {b0.A, b0.B, b0.C}, 3'd7);
        chk("err_count", b0.err_count, exp_err);
        chk("fail_seen", b0.fail_seen, ff >= 0);
        if (ff >= 0) chk("first_fail", b0.first_fail, ff);
        chk("pass", b0.pass, exp_err == 0);
    endtask
    task automatic watch();
        int c1 = 0, c2 = 0, c3 = 0;
        for (int c = 2; c <= 700 && (c1 == 0 || c2 == 0 || c3 == 0); c++) begin
            @(negedge clk);
            if (c1 == 0 && b1.done) c1 = c;
            if (c2 == 0 && b2.done) c2 = c;
            if (c3 == 0 && b3.done) c3 = c;
        end
        chk("d1_latency", c1, 161);
        chk("d1_err", b1.err_count, 10);
        chk("d1_first_fail", b1.first_fail, 0);
        chk("d1_pass", b1.pass, 0);
        chk("d2_latency", c2, 241);
        chk("d2_err", b2.err_count, 120);
        chk("d2_fail_seen", b2.fail_seen, 1);
        chk("d3_latency", c3, 529);
        chk("d3_err_sat", b3.err_count, 255);
        chk("d3_pass", b3.pass, 0);
    endtask
    initial begin
        rst_n = 1'b0;
        {b3.start, b2.start, b1.start, b0.start} = 4'b0;
        b0.x_in = 1'b0;
        b0.y_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_d0", o0, 0);
        chk("reset_d1", o1, 0);
        rst_n = 1'b1;
        kick(4'b1111);
        fork
            run_d0(0, 28);
            watch();
        join
        kick(4'b0001);
        run_d0(1, -1);
        kick(4'b0001);
        run_d0(2, -1);
        repeat (3) begin
            kick(4'b0001);
            run_d0(3, -1);
        end
        kick(4'b0001);
        for (int t = 0; t < 44; t++) begin
            b0.x_in = 1'b0;
            b0.y_in = yt[t / H];
            @(negedge clk);
        end
        chk("pre_reset_busy", b0.busy, 1);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", o0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        kick(4'b0001);
        run_d0(0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
